// File: rtl/apb_periph_pkg.sv
// Shared constants for apb_periph_bank: slot word offsets, APB phase FSM encoding, CTRL bits.
package apb_periph_pkg;

  // Word offsets inside a slot, i.e. paddr[31:2]
  typedef logic [29:0] word_off_t;

  localparam word_off_t OFF_CTRL    = 30'd0;
  localparam word_off_t OFF_COUNT   = 30'd1;
  localparam word_off_t OFF_COMPARE = 30'd2;
  localparam word_off_t OFF_STATUS  = 30'd3;

  localparam word_off_t OFF_ID      = 30'd0;
  localparam word_off_t OFF_SCRATCH = 30'd1;
  localparam word_off_t OFF_ERRCNT  = 30'd2;

  // Encoding is visible on the debug state port: 0 idle, 1 setup, 2 access
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  function automatic logic is_onehot3(input logic [2:0] s);
    return (s == 3'b001) || (s == 3'b010) || (s == 3'b100);
  endfunction

endpackage

// File: rtl/apb_timer.sv
// Slot1 timer: free-running counter with compare match, W1C status and level interrupt.
module apb_timer
  import apb_periph_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_en_i,
  input  word_off_t   off_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rd_data_o,
  output logic        irq_o
);

  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [31:0] count_inc;
  logic        count_wr;
  logic        match_set;

  always_comb begin
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    compare_d = compare_q;
    match_d   = match_q;
    count_inc = count_q + 32'd1;
    count_wr  = wr_en_i && (off_i == OFF_COUNT);
    // A software COUNT write replaces the increment, so it cannot raise a match
    match_set = ctrl_q[CTRL_EN_BIT] && !count_wr && (count_inc == compare_q);

    if (ctrl_q[CTRL_EN_BIT]) count_d = count_inc;
    if (wr_en_i) begin
      case (off_i)
        OFF_CTRL:    ctrl_d    = wr_data_i[1:0];
        OFF_COUNT:   count_d   = wr_data_i;
        OFF_COMPARE: compare_d = wr_data_i;
        OFF_STATUS:  if (wr_data_i[0]) match_d = 1'b0;
        default: ;
      endcase
    end
    if (match_set) match_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      compare_q <= '0;
      match_q   <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (off_i)
      OFF_CTRL:    rd_data_o = {30'd0, ctrl_q};
      OFF_COUNT:   rd_data_o = count_q;
      OFF_COMPARE: rd_data_o = compare_q;
      OFF_STATUS:  rd_data_o = {31'd0, match_q};
      default:     rd_data_o = '0;
    endcase
  end

  assign irq_o = match_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: rtl/apb_periph_bank.sv
// Three-slot zero-wait APB2 bank: slot0 register file, slot1 timer, slot2 ID/scratch/ERRCNT.
// Define APB_PROT_CHK_EN to build the protocol checker that counts into ERRCNT.
module apb_periph_bank
  import apb_periph_pkg::*;
#(
  parameter int          RF_WORDS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA9B0_0001,
  parameter int          CNT_W    = 8
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq,
  output logic [1:0]  dbg_state_o
);

  // Transfer handshake: one SETUP cycle (|psel, !penable) then one ACCESS cycle
  // (|psel, penable); no wait states. Writes commit at the edge ending ACCESS,
  // read data is captured at the edge ending SETUP and cleared after ACCESS.
  apb_state_e  state_q;
  logic        setup_ph;
  logic        access_ph;
  logic        onehot;
  logic        wr_commit;
  word_off_t   word_off;
  logic [3:0]  rf_idx;
  logic [31:0] rf_q [RF_WORDS];
  logic [31:0] scratch_q;
  logic [31:0] timer_rd;
  logic [31:0] slot2_rd;
  logic [31:0] rd_val;
  logic [31:0] errcnt_rd;
  logic        unused_addr;

  assign setup_ph    = (|psel) & ~penable;
  assign access_ph   = (|psel) & penable;
  assign onehot      = is_onehot3(psel);
  assign wr_commit   = (state_q == ST_SETUP) & access_ph & pwrite & onehot;
  // Timer and slot2 decode the full word offset; the register file wraps on paddr[5:2]
  assign word_off    = paddr[31:2];
  assign rf_idx      = paddr[5:2] & 4'(RF_WORDS - 1);
  assign unused_addr = ^paddr[1:0];
  assign dbg_state_o = state_q;

  apb_timer u_timer (
    .clk_i     (hclk),
    .rst_ni    (hresetn),
    .wr_en_i   (wr_commit & psel[1]),
    .off_i     (word_off),
    .wr_data_i (pwdata),
    .rd_data_o (timer_rd),
    .irq_o     (irq)
  );

  always_comb begin
    slot2_rd = '0;
    rd_val   = '0;
    case (word_off)
      OFF_ID:      slot2_rd = ID_VALUE;
      OFF_SCRATCH: slot2_rd = scratch_q;
      OFF_ERRCNT:  slot2_rd = errcnt_rd;
      default:     slot2_rd = '0;
    endcase
    case (psel)
      3'b001:  rd_val = rf_q[rf_idx];
      3'b010:  rd_val = timer_rd;
      3'b100:  rd_val = slot2_rd;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      prdata  <= '0;
    end else begin
      prdata <= (setup_ph && !pwrite) ? rd_val : '0;
      case (state_q)
        ST_IDLE: if (setup_ph) state_q <= ST_SETUP;
        ST_SETUP: begin
          if (penable)        state_q <= ST_ACCESS;
          else if (!setup_ph) state_q <= ST_IDLE;
        end
        ST_ACCESS: state_q <= setup_ph ? ST_SETUP : ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      for (int i = 0; i < RF_WORDS; i++) rf_q[i] <= '0;
      scratch_q <= '0;
    end else begin
      if (wr_commit && psel[0]) rf_q[rf_idx] <= pwdata;
      if (wr_commit && psel[2] && (word_off == OFF_SCRATCH)) scratch_q <= pwdata;
    end
  end

`ifdef APB_PROT_CHK_EN
  localparam logic [32:0] ERR_MAX = (33'd1 << CNT_W) - 33'd1;

  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic [2:0]       psel_p_q;
  logic [31:0]      paddr_p_q;
  logic             pwrite_p_q;
  logic             e_idle, e_drop, e_chg, e_hot;
  logic [2:0]       err_n;
  logic [32:0]      err_sum;

  always_comb begin
    e_idle   = (state_q == ST_IDLE) && penable;
    e_drop   = (state_q == ST_SETUP) && !penable;
    // Previous-cycle values are the SETUP values whenever we are in SETUP
    e_chg    = (state_q == ST_SETUP) && penable &&
               ((psel != psel_p_q) || (paddr != paddr_p_q) || (pwrite != pwrite_p_q));
    e_hot    = setup_ph && !onehot;
    err_n    = 3'(e_idle) + 3'(e_drop) + 3'(e_chg) + 3'(e_hot);
    err_sum  = 33'(errcnt_q) + 33'(err_n);
    errcnt_d = (err_sum > ERR_MAX) ? ERR_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
    if (wr_commit && psel[2] && (word_off == OFF_ERRCNT)) errcnt_d = '0;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      errcnt_q   <= '0;
      psel_p_q   <= '0;
      paddr_p_q  <= '0;
      pwrite_p_q <= 1'b0;
    end else begin
      errcnt_q   <= errcnt_d;
      psel_p_q   <= psel;
      paddr_p_q  <= paddr;
      pwrite_p_q <= pwrite;
    end
  end

  assign errcnt_rd = 32'(errcnt_q);
`else
  logic [CNT_W-1:0] unused_errcnt;
  assign unused_errcnt = '0;
  assign errcnt_rd     = '0;
`endif

endmodule

// File: tb/tb_apb_periph_bank.sv
// Bench for apb_periph_bank: transfer-level reference model, per-cycle output compare, directed and random traffic.
module tb_apb_periph_bank;

  localparam int          RF_WORDS = 16;
  localparam logic [31:0] ID_VALUE = 32'hA9B0_0001;
  localparam int          CNT_W    = 8;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [31:0] m_rf [RF_WORDS];
  logic [31:0] m_scratch;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  bit          m_en;
  bit          m_irq_en;
  bit          m_match;
  int unsigned m_err;

  logic [31:0] exp_prdata = '0;
  logic        exp_irq    = 1'b0;
  logic [1:0]  exp_state  = '0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  always #5 hclk = ~hclk;

  apb_periph_bank #(
    .RF_WORDS (RF_WORDS),
    .ID_VALUE (ID_VALUE),
    .CNT_W    (CNT_W)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .irq         (irq),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit onehot(input logic [2:0] s);
    return $countones(s) == 1;
  endfunction

  // What a read of (slot, address) returns given the current model registers
  function automatic logic [31:0] m_read(input logic [2:0] s, input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (!onehot(s)) return 32'd0;
    if (s[0]) return m_rf[int'(a[5:2]) % RF_WORDS];
    if (s[1]) begin
      case (w)
        30'd0:   return {30'd0, m_irq_en, m_en};
        30'd1:   return m_count;
        30'd2:   return m_compare;
        30'd3:   return {31'd0, m_match};
        default: return 32'd0;
      endcase
    end
    case (w)
      30'd0:   return ID_VALUE;
      30'd1:   return m_scratch;
      30'd2:   return 32'(m_err);
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    for (int i = 0; i < RF_WORDS; i++) m_rf[i] = '0;
    m_scratch = '0; m_count = '0; m_compare = '0;
    m_en = 1'b0; m_irq_en = 1'b0; m_match = 1'b0; m_err = 0;
  endtask

  // One clock of model time; commit says whether a write lands at this edge
  task automatic m_step(input bit commit);
    logic [31:0] inc;
    logic [29:0] w;
    bit wr_cnt, set, clr, old_en;
    w      = paddr[31:2];
    inc    = m_count + 32'd1;
    old_en = m_en;
    wr_cnt = commit && psel[1] && (w == 30'd1);
    set    = m_en && !wr_cnt && (inc == m_compare);
    clr    = commit && psel[1] && (w == 30'd3) && pwdata[0];
    if (commit) begin
      if (psel[0]) m_rf[int'(paddr[5:2]) % RF_WORDS] = pwdata;
      else if (psel[1]) begin
        case (w)
          30'd0: begin m_en = pwdata[0]; m_irq_en = pwdata[1]; end
          30'd1: m_count = pwdata;
          30'd2: m_compare = pwdata;
          default: ;
        endcase
      end else begin
        case (w)
          30'd1: m_scratch = pwdata;
          30'd2: m_err = 0;
          default: ;
        endcase
      end
    end
    if (!wr_cnt && old_en) m_count = inc;
    if (set) m_match = 1'b1;
    else if (clr) m_match = 1'b0;
  endtask

  // kind: 0 idle cycle, 1 setup cycle, 2 access cycle (what the driver is doing)
  task automatic cycle(input int kind);
    bit commit, rd_setup;
    logic [31:0] rv;
    @(posedge hclk);
    if (!hresetn) begin
      m_reset();
      exp_prdata = '0;
      exp_state  = 2'd0;
    end else begin
      commit   = (kind == 2) && pwrite && onehot(psel);
      rd_setup = (kind == 1) && !pwrite;
      rv       = rd_setup ? m_read(psel, paddr) : 32'd0;
      if (rd_setup) exp_q.push_back(rv);
      m_step(commit);
      exp_prdata = rv;
      exp_state  = 2'(kind);
    end
    exp_irq = m_match && m_irq_en;
    @(negedge hclk);
  endtask

  task automatic bus_idle(input int n);
    psel = 3'b000; penable = 1'b0;
    for (int i = 0; i < n; i++) cycle(0);
  endtask

  task automatic apb_write(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    psel = s; paddr = a; pwrite = 1'b1; pwdata = d; penable = 1'b0;
    cycle(1);
    penable = 1'b1;
    cycle(2);
  endtask

  task automatic apb_read(input logic [2:0] s, input logic [31:0] a, output logic [31:0] d);
    logic [31:0] e;
    psel = s; paddr = a; pwrite = 1'b0; pwdata = $urandom; penable = 1'b0;
    cycle(1);
    d = prdata;
    e = exp_q.pop_front();
    check("rd_data", d, e);
    penable = 1'b1;
    cycle(2);
  endtask

  always @(negedge hclk) begin
    if (chk_en) begin
      check("prdata", prdata, exp_prdata);
      check("irq", 32'(irq), 32'(exp_irq));
      check("state", 32'(dbg_state), 32'(exp_state));
    end
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int k;
    logic [2:0]  s;
    logic [29:0] w;
    logic [31:0] a, d, c0, errexp;

    hresetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    m_reset();
    chk_en = 1'b1;
    cycle(0); cycle(0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    hresetn = 1'b1;
    bus_idle(1);

    // Register file write then read
    apb_write(3'b001, 32'h8, 32'hDEAD_BEEF);
    apb_read(3'b001, 32'h8, rd);
    check("rf_read_access", rd, 32'hDEAD_BEEF);
    check("rf_read_after", prdata, 32'd0);

    // Timer compare and interrupt
    apb_write(3'b010, 32'h8, 32'd5);
    apb_write(3'b010, 32'h0, 32'd3);
    psel = 3'b000; penable = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cycle(0);
      if (i == 4) check("irq_before_match", 32'(irq), 32'd0);
    end
    check("irq_at_match", 32'(irq), 32'd1);
    check("model_count", m_count, 32'd5);
    apb_write(3'b010, 32'hC, 32'd1);
    check("irq_w1c", 32'(irq), 32'd0);

    // Match set on the same edge as a W1C clear keeps the flag
    c0 = m_count;
    apb_write(3'b010, 32'h8, c0 + 32'd4);
    apb_write(3'b010, 32'hC, 32'd1);
    check("match_beats_w1c", 32'(irq), 32'd1);
    apb_write(3'b010, 32'hC, 32'd1);
    check("irq_cleared", 32'(irq), 32'd0);
    apb_write(3'b010, 32'h0, 32'd0);

    // Counter wrap
    apb_write(3'b010, 32'h4, 32'hFFFF_FFFE);
    apb_write(3'b010, 32'h0, 32'd1);
    bus_idle(3);
    apb_read(3'b010, 32'h4, rd);
    check("count_wrap", rd, 32'd1);
    apb_write(3'b010, 32'h0, 32'd0);

    // Slot2 ID, scratch, unmapped
    apb_read(3'b100, 32'h0, rd);
    check("id_read", rd, 32'hA9B0_0001);
    apb_write(3'b100, 32'h0, 32'h1234);
    apb_read(3'b100, 32'h0, rd);
    check("id_readonly", rd, 32'hA9B0_0001);
    apb_read(3'b100, 32'h44, rd);
    check("unmapped_read", rd, 32'd0);
    apb_write(3'b100, 32'h4, 32'hCAFE_F00D);
    apb_read(3'b100, 32'h4, rd);
    check("scratch_read", rd, 32'hCAFE_F00D);

    // Protocol errors: penable in idle, then a non-one-hot write transfer
    apb_write(3'b100, 32'h8, 32'd0);
    bus_idle(1);
    psel = 3'b000; penable = 1'b1; pwrite = 1'b0;
    cycle(0);
    psel = 3'b011; paddr = 32'h8; pwrite = 1'b1; pwdata = 32'h5555_5555; penable = 1'b0;
    cycle(1);
    penable = 1'b1;
    cycle(2);
`ifdef APB_PROT_CHK_EN
    m_err  = m_err + 2;
    errexp = 32'd2;
`else
    errexp = 32'd0;
`endif
    apb_read(3'b100, 32'h8, rd);
    check("errcnt", rd, errexp);
    apb_read(3'b001, 32'h8, rd);
    check("no_commit_bad_psel", rd, 32'hDEAD_BEEF);

    // Reset during the ACCESS of a write aborts it
    apb_write(3'b001, 32'hC, 32'h1111_1111);
    psel = 3'b001; paddr = 32'hC; pwrite = 1'b1; pwdata = 32'h7777_7777; penable = 1'b0;
    cycle(1);
    penable = 1'b1; hresetn = 1'b0;
    cycle(2);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    check("rst_mid_prdata", prdata, 32'd0);
    hresetn = 1'b1;
    bus_idle(1);
    apb_read(3'b001, 32'hC, rd);
    check("rst_mid_word", rd, 32'd0);

    // Back-to-back: word 15 and word 31 alias
    apb_write(3'b001, 32'h3C, 32'h0BAD_F00D);
    apb_read(3'b001, 32'h7C, rd);
    check("rf_wrap_alias", rd, 32'h0BAD_F00D);

    // Random legal traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 2);
      s = 3'b001 << k;
      case (k)
        0:       w = 30'($urandom_range(0, 31));
        1:       w = 30'($urandom_range(0, 5));
        default: w = 30'($urandom_range(0, 4));
      endcase
      if ($urandom_range(0, 15) == 0) w = 30'($urandom);
      a = {w, 2'($urandom_range(0, 3))};
      d = $urandom;
      if (k == 1 && w == 30'd2) d = m_count + 32'($urandom_range(3, 12));
      if (k == 1 && w == 30'd1 && $urandom_range(0, 1) == 1)
        d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) apb_write(s, a, d);
      else apb_read(s, a, rd);
      if ($urandom_range(0, 3) == 0) bus_idle($urandom_range(1, 3));
    end
    bus_idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
